// File: rtl/conv_engine_arbiter.sv
// Round-robin job arbiter sharing one conv engine between two streaming clients.
// Whole jobs are granted; handshakes are routed combinationally while granted.
module conv_engine_arbiter #(
    parameter int unsigned M  = 112,
    parameter int unsigned N  = 49,
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        job_req,
    output logic [1:0]        job_gnt,
    output logic [1:0]        job_done,
    input  logic [2*XW-1:0]   c_x_data,
    input  logic [1:0]        c_x_valid,
    output logic [1:0]        c_x_ready,
    input  logic [2*XW-1:0]   c_f_data,
    input  logic [1:0]        c_f_valid,
    output logic [1:0]        c_f_ready,
    output logic [YW-1:0]     c_y_data,
    output logic [1:0]        c_y_valid,
    input  logic [1:0]        c_y_ready,
    output logic [XW-1:0]     e_x_data,
    output logic              e_x_valid,
    input  logic              e_x_ready,
    output logic [XW-1:0]     e_f_data,
    output logic              e_f_valid,
    input  logic              e_f_ready,
    input  logic [YW-1:0]     e_y_data,
    input  logic              e_y_valid,
    output logic              e_y_ready
);

    localparam int unsigned NY  = M - N + 1;
    localparam int unsigned XCW = $clog2(M + 1);
    localparam int unsigned FCW = $clog2(N + 1);
    localparam int unsigned YCW = $clog2(NY + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t         state;
    logic           g;
    logic           last;
    logic [XCW-1:0] xcnt;
    logic [FCW-1:0] fcnt;
    logic [YCW-1:0] ycnt;

    logic x_open, f_open, x_hs, f_hs, y_hs;
    logic x_full, f_full, pick;

    // Both clients asking: the one not served last wins.
    assign pick = (job_req == 2'b11) ? ~last : job_req[1];

    assign x_hs   = e_x_valid & e_x_ready;
    assign f_hs   = e_f_valid & e_f_ready;
    assign y_hs   = e_y_valid & e_y_ready;
    assign x_full = (xcnt == XCW'(M)) || (x_hs && (xcnt == XCW'(M - 1)));
    assign f_full = (fcnt == FCW'(N)) || (f_hs && (fcnt == FCW'(N - 1)));

    assign c_y_data = e_y_data;

    // Zero-latency handshake routing to/from the granted client only.
    always_comb begin
        c_x_ready = '0;
        c_f_ready = '0;
        c_y_valid = '0;
        x_open    = (state == LOAD) && (xcnt < XCW'(M));
        f_open    = (state == LOAD) && (fcnt < FCW'(N));
        e_x_valid = x_open & c_x_valid[g];
        e_f_valid = f_open & c_f_valid[g];
        e_y_ready = (state == DRAIN) & c_y_ready[g];
        c_x_ready[g] = x_open & e_x_ready;
        c_f_ready[g] = f_open & e_f_ready;
        c_y_valid[g] = (state == DRAIN) & e_y_valid;
        if (state == IDLE) begin
            e_x_data = '0;
            e_f_data = '0;
        end else begin
            e_x_data = g ? c_x_data[2*XW-1:XW] : c_x_data[XW-1:0];
            e_f_data = g ? c_f_data[2*XW-1:XW] : c_f_data[XW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            job_gnt  <= '0;
            job_done <= '0;
            g        <= 1'b0;
            last     <= 1'b1;
            xcnt     <= '0;
            fcnt     <= '0;
            ycnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (job_req != 2'b00) begin
                        g       <= pick;
                        job_gnt <= pick ? 2'b10 : 2'b01;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (x_hs) xcnt <= xcnt + XCW'(1);
                    if (f_hs) fcnt <= fcnt + FCW'(1);
                    if (x_full && f_full) state <= DRAIN;
                end
                DRAIN: begin
                    if (y_hs) begin
                        ycnt <= ycnt + YCW'(1);
                        if (ycnt == YCW'(NY - 1)) begin
                            job_done <= g ? 2'b10 : 2'b01;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    job_done <= '0;
                    job_gnt  <= '0;
                    last     <= g;
                    xcnt     <= '0;
                    fcnt     <= '0;
                    ycnt     <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Directed bench for conv_engine_arbiter with a small behavioural conv engine (M=8, N=3).
module tb_conv_engine_arbiter;

    localparam int unsigned M  = 8;
    localparam int unsigned N  = 3;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 26;
    localparam int unsigned NY = M - N + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        job_req;
    logic [1:0]        job_gnt;
    logic [1:0]        job_done;
    logic [2*XW-1:0]   c_x_data;
    logic [1:0]        c_x_valid;
    logic [1:0]        c_x_ready;
    logic [2*XW-1:0]   c_f_data;
    logic [1:0]        c_f_valid;
    logic [1:0]        c_f_ready;
    logic [YW-1:0]     c_y_data;
    logic [1:0]        c_y_valid;
    logic [1:0]        c_y_ready;
    logic [XW-1:0]     e_x_data;
    logic              e_x_valid;
    logic              e_x_ready;
    logic [XW-1:0]     e_f_data;
    logic              e_f_valid;
    logic              e_f_ready;
    logic [YW-1:0]     e_y_data;
    logic              e_y_valid;
    logic              e_y_ready;

    int checks   = 0;
    int failures = 0;

    conv_engine_arbiter #(.M(M), .N(N), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset),
        .job_req(job_req), .job_gnt(job_gnt), .job_done(job_done),
        .c_x_data(c_x_data), .c_x_valid(c_x_valid), .c_x_ready(c_x_ready),
        .c_f_data(c_f_data), .c_f_valid(c_f_valid), .c_f_ready(c_f_ready),
        .c_y_data(c_y_data), .c_y_valid(c_y_valid), .c_y_ready(c_y_ready),
        .e_x_data(e_x_data), .e_x_valid(e_x_valid), .e_x_ready(e_x_ready),
        .e_f_data(e_f_data), .e_f_valid(e_f_valid), .e_f_ready(e_f_ready),
        .e_y_data(e_y_data), .e_y_valid(e_y_valid), .e_y_ready(e_y_ready)
    );

    always #5 clk = ~clk;

    // Behavioural engine: collect M x and N f beats, then emit NY correlation outputs.
    logic signed [XW-1:0] ex_mem [M];
    logic signed [XW-1:0] ef_mem [N];
    logic signed [YW-1:0] eng_y;
    int exn, efn, yidx;

    always @(posedge clk) begin
        if (reset) begin
            exn  <= 0;
            efn  <= 0;
            yidx <= 0;
        end else begin
            if (e_x_valid && e_x_ready) begin
                if (exn < int'(M)) ex_mem[3'(exn)] <= e_x_data;
                exn <= exn + 1;
            end
            if (e_f_valid && e_f_ready) begin
                if (efn < int'(N)) ef_mem[2'(efn)] <= e_f_data;
                efn <= efn + 1;
            end
            if (e_y_valid && e_y_ready) begin
                if (yidx == int'(NY) - 1) begin
                    exn  <= 0;
                    efn  <= 0;
                    yidx <= 0;
                end else begin
                    yidx <= yidx + 1;
                end
            end
        end
    end

    always_comb begin
        eng_y = '0;
        for (int j = 0; j < int'(N); j++)
            eng_y = eng_y + YW'(ex_mem[3'(yidx + j)]) * YW'(ef_mem[2'(j)]);
    end

    assign e_y_data  = eng_y;
    assign e_y_valid = (exn == int'(M)) && (efn == int'(N)) && (yidx < int'(NY));

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input logic [1:0] exp);
        int cyc = 0;
        #1;
        while (job_gnt == 2'b00 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (job_gnt !== exp) begin
            failures++;
            $display("FAIL grant got=%b exp=%b", job_gnt, exp);
        end
    endtask

    // Stream n beats of value base+step*i from client c on the x or f path.
    task automatic feed(input int c, input bit is_f, input int base, input int step, input int n);
        logic [1:0]    cm = (c == 0) ? 2'b01 : 2'b10;
        logic [XW-1:0] v;
        logic          rdy;
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            v = XW'(base + step * sent);
            if (is_f) begin
                c_f_valid = c_f_valid | cm;
                c_f_data[c*XW +: XW] = v;
            end else begin
                c_x_valid = c_x_valid | cm;
                c_x_data[c*XW +: XW] = v;
            end
            #1;
            rdy = is_f ? |(c_f_ready & cm) : |(c_x_ready & cm);
            if (rdy) begin
                checks++;
                if ((is_f ? e_f_data : e_x_data) !== v) begin
                    failures++;
                    $display("FAIL route_data client=%0d f=%0d got=%h exp=%h",
                             c, is_f, is_f ? e_f_data : e_x_data, v);
                end
                sent++;
            end
            checks++;
            if ((c_x_ready & ~cm) !== 2'b00 || (c_f_ready & ~cm) !== 2'b00 || (c_y_valid & ~cm) !== 2'b00) begin
                failures++;
                $display("FAIL other_client_quiet xr=%b fr=%b yv=%b exp=0", c_x_ready & ~cm,
                         c_f_ready & ~cm, c_y_valid & ~cm);
            end
        end
        if (sent < n) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout client=%0d f=%0d sent=%0d exp=%0d", c, is_f, sent, n);
        end
    endtask

    // Collect NY y beats for client c (x base, f all ones), then check the done pulse.
    task automatic recv_y(input int c, input bit toggle, input int base);
        logic [1:0]    cm = (c == 0) ? 2'b01 : 2'b10;
        logic [YW-1:0] ey;
        int got = 0;
        int cyc = 0;
        while (got < int'(NY) && cyc < 80) begin
            @(negedge clk);
            c_y_ready = (toggle && (cyc % 2 == 1)) ? 2'b00 : cm;
            cyc++;
            #1;
            checks++;
            if (e_y_ready !== |(c_y_ready & cm)) begin
                failures++;
                $display("FAIL y_ready_follow got=%b exp=%b", e_y_ready, |(c_y_ready & cm));
            end
            checks++;
            if (job_done !== 2'b00) begin
                failures++;
                $display("FAIL early_done got=%b exp=00 after %0d beats", job_done, got);
            end
            if (|(c_y_valid & cm) && |(c_y_ready & cm)) begin
                ey = YW'(3 * base + 3 * got + 3);
                checks++;
                if (c_y_data !== ey) begin
                    failures++;
                    $display("FAIL y_data beat=%0d got=%0d exp=%0d", got, c_y_data, ey);
                end
                got++;
            end
        end
        if (got < int'(NY)) begin
            checks++;
            failures++;
            $display("FAIL y_timeout got=%0d exp=%0d", got, NY);
        end
        @(negedge clk);
        c_y_ready = 2'b00;
        #1;
        checks++;
        if (job_done !== cm || job_gnt !== cm) begin
            failures++;
            $display("FAIL done_pulse done=%b gnt=%b exp=%b", job_done, job_gnt, cm);
        end
        @(negedge clk);
        #1;
        checks++;
        if (job_done !== 2'b00 || job_gnt !== 2'b00) begin
            failures++;
            $display("FAIL done_release done=%b gnt=%b exp=00", job_done, job_gnt);
        end
    endtask

    task automatic do_job(input int c, input int xbase);
        feed(c, 1'b0, xbase, 1, M);
        feed(c, 1'b1, 1, 0, N);
        @(negedge clk);
        c_x_valid = 2'b00;
        c_f_valid = 2'b00;
        recv_y(c, 1'b0, xbase);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        job_req   = 2'b00;
        c_x_data  = {XW'(7), XW'(5)};
        c_x_valid = 2'b11;
        c_f_data  = {XW'(3), XW'(2)};
        c_f_valid = 2'b11;
        c_y_ready = 2'b11;
        e_x_ready = 1'b1;
        e_f_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (job_gnt !== 2'b00 || job_done !== 2'b00) begin
            failures++;
            $display("FAIL reset_gnt_done gnt=%b done=%b exp=00", job_gnt, job_done);
        end
        checks++;
        if (c_x_ready !== 2'b00 || c_f_ready !== 2'b00 || c_y_valid !== 2'b00 ||
            e_x_valid !== 1'b0 || e_f_valid !== 1'b0 || e_y_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshakes xr=%b fr=%b yv=%b exv=%b efv=%b eyr=%b exp=0",
                     c_x_ready, c_f_ready, c_y_valid, e_x_valid, e_f_valid, e_y_ready);
        end
        checks++;
        if (e_x_data !== '0 || e_f_data !== '0) begin
            failures++;
            $display("FAIL reset_idle_data x=%h f=%h exp=0", e_x_data, e_f_data);
        end
        c_x_valid = 2'b00;
        c_f_valid = 2'b00;
        c_y_ready = 2'b00;
    endtask

    // x=1..8, f=1,1,1 -> y=6,9,12,15,18,21 to client 0.
    task automatic test_single_job();
        @(negedge clk);
        job_req = 2'b01;
        #1;
        checks++;
        if (job_gnt !== 2'b00) begin
            failures++;
            $display("FAIL grant_latency got=%b exp=00", job_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (job_gnt !== 2'b01) begin
            failures++;
            $display("FAIL grant_next_cycle got=%b exp=01", job_gnt);
        end
        job_req = 2'b00;
        do_job(0, 1);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        pulse_reset();
        job_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(exp_g);
            do_job(i % 2, (i % 2 == 0) ? 1 + i : 20 + i);
        end
        job_req = 2'b00;
    endtask

    task automatic test_x_overflow();
        @(negedge clk);
        job_req = 2'b01;
        @(negedge clk);
        wait_gnt(2'b01);
        job_req = 2'b00;
        feed(0, 1'b0, 1, 1, M);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_x_data[XW-1:0] = XW'(9);
            #1;
            checks++;
            if (c_x_ready[0] !== 1'b0 || e_x_valid !== 1'b0) begin
                failures++;
                $display("FAIL x_ninth_beat ready=%b e_valid=%b exp=0", c_x_ready[0], e_x_valid);
            end
        end
        feed(0, 1'b1, 1, 0, N);
        @(negedge clk);
        c_x_valid = 2'b00;
        c_f_valid = 2'b00;
        checks++;
        if (exn != int'(M)) begin
            failures++;
            $display("FAIL engine_x_count got=%0d exp=%0d", exn, M);
        end
        recv_y(0, 1'b0, 1);
    endtask

    task automatic test_y_backpressure();
        @(negedge clk);
        job_req = 2'b01;
        @(negedge clk);
        wait_gnt(2'b01);
        job_req = 2'b00;
        feed(0, 1'b0, 5, 1, M);
        feed(0, 1'b1, 1, 0, N);
        @(negedge clk);
        c_x_valid = 2'b00;
        c_f_valid = 2'b00;
        recv_y(0, 1'b1, 5);
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        job_req = 2'b01;
        @(negedge clk);
        wait_gnt(2'b01);
        feed(0, 1'b0, 1, 1, 5);
        @(negedge clk);
        c_x_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (job_gnt !== 2'b00 || job_done !== 2'b00 || e_x_valid !== 1'b0 || c_x_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_job gnt=%b done=%b exv=%b xr=%b exp=0",
                     job_gnt, job_done, e_x_valid, c_x_ready);
        end
        wait_gnt(2'b01);
        job_req = 2'b00;
        do_job(0, 2);
    endtask

    task automatic test_req_drop();
        @(negedge clk);
        job_req = 2'b01;
        @(negedge clk);
        wait_gnt(2'b01);
        job_req = 2'b10;
        do_job(0, 3);
        wait_gnt(2'b10);
        job_req = 2'b00;
        do_job(1, 4);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_x_overflow();
        test_y_backpressure();
        test_reset_mid_job();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
